// File: rtl/neureka_binconv_pe_accum.sv
// BinConv PE reduction stage: bit-serial accumulation of per-column partial sums.
// SUM mode reduces all enabled columns into lane 0; DEPTHWISE keeps one lane per column.
// One registered output slot with valid/ready; a beat accepted in the pop cycle starts
// the next group, so back-to-back single-beat groups sustain one result per cycle.
module neureka_binconv_pe_accum #(
  parameter int unsigned N_COL     = 16,
  parameter int unsigned COL_W     = 20,
  parameter int unsigned MAX_BEATS = 8,
  parameter int unsigned ACC_W     = COL_W + $clog2(N_COL) + MAX_BEATS,
  parameter int unsigned BCNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     cfg_mode_i,
  input  logic [BCNT_W-1:0]        cfg_nbeats_i,
  input  logic                     cfg_signed_i,
  input  logic [N_COL-1:0]         cfg_col_en_i,
  input  logic                     cfg_pad_en_i,
  input  logic [ACC_W-1:0]         cfg_pad_value_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [N_COL*COL_W-1:0]   in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [N_COL*ACC_W-1:0]   out_data_o,
  output logic [N_COL-1:0]         out_strb_o,
  output logic                     busy_o,
  output logic [BCNT_W-1:0]        beat_cnt_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StOut   = 2'd2;

  localparam logic [BCNT_W-1:0] MaxBeats = BCNT_W'(MAX_BEATS);
  localparam logic [BCNT_W-1:0] OneBeat  = BCNT_W'(1);

  logic [1:0]                   state_q, state_d;
  logic [BCNT_W-1:0]            beat_cnt_q;
  logic [N_COL-1:0][ACC_W-1:0]  acc_q;
  logic                         out_valid_q;
  logic [N_COL-1:0][ACC_W-1:0]  out_data_q;
  logic [N_COL-1:0]             out_strb_q;

  // Group configuration captured on the first beat
  logic                         mode_q;
  logic [BCNT_W-1:0]            nbeats_q;
  logic                         signed_q;
  logic [N_COL-1:0]             col_en_q;
  logic                         pad_en_q;
  logic [ACC_W-1:0]             pad_value_q;

  logic                         first_beat;
  logic                         beat_acc;
  logic                         last_beat;
  logic                         negate;
  logic [BCNT_W-1:0]            nbeats_norm;
  logic                         eff_mode;
  logic [BCNT_W-1:0]            eff_nbeats;
  logic                         eff_signed;
  logic [N_COL-1:0]             eff_col_en;
  logic                         eff_pad_en;
  logic [ACC_W-1:0]             eff_pad_value;
  logic [N_COL-1:0][ACC_W-1:0]  term;
  logic [ACC_W-1:0]             sum_terms;
  logic [N_COL-1:0][ACC_W-1:0]  acc_upd;
  logic [N_COL-1:0][ACC_W-1:0]  res_data;
  logic [N_COL-1:0]             res_strb;

  assign in_ready_o  = !out_valid_q || out_ready_i;
  assign beat_acc    = in_valid_i && in_ready_o && !clear_i;
  assign first_beat  = (beat_cnt_q == '0);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_strb_o  = out_strb_q;
  assign beat_cnt_o  = beat_cnt_q;
  assign busy_o      = (beat_cnt_q != '0) || out_valid_q;

  // Effective config: live inputs on the first beat, latched copy afterwards
  always_comb begin
    nbeats_norm = cfg_nbeats_i;
    if (cfg_nbeats_i == '0) begin
      nbeats_norm = OneBeat;
    end else if (cfg_nbeats_i > MaxBeats) begin
      nbeats_norm = MaxBeats;
    end
    eff_mode      = first_beat ? cfg_mode_i      : mode_q;
    eff_nbeats    = first_beat ? nbeats_norm     : nbeats_q;
    eff_signed    = first_beat ? cfg_signed_i    : signed_q;
    eff_col_en    = first_beat ? cfg_col_en_i    : col_en_q;
    eff_pad_en    = first_beat ? cfg_pad_en_i    : pad_en_q;
    eff_pad_value = first_beat ? cfg_pad_value_i : pad_value_q;
    last_beat     = (beat_cnt_q == eff_nbeats - OneBeat);
    // The MSB bit-plane of a signed operand carries negative weight
    negate        = eff_signed && (eff_nbeats > OneBeat) && last_beat;
  end

  // Per-column weighted terms and the per-lane accumulator update
  always_comb begin
    sum_terms = '0;
    for (int k = 0; k < N_COL; k++) begin
      term[k] = '0;
      if (eff_col_en[k]) begin
        term[k] = {{(ACC_W-COL_W){in_data_i[k*COL_W+COL_W-1]}}, in_data_i[k*COL_W +: COL_W]}
                  << beat_cnt_q;
      end
      sum_terms = sum_terms + term[k];
    end
    for (int k = 0; k < N_COL; k++) begin
      if (eff_mode) begin
        acc_upd[k] = negate ? (acc_q[k] - term[k]) : (acc_q[k] + term[k]);
      end else if (k == 0) begin
        acc_upd[k] = negate ? (acc_q[k] - sum_terms) : (acc_q[k] + sum_terms);
      end else begin
        acc_upd[k] = '0;
      end
    end
  end

  // Result formation including padding substitution
  always_comb begin
    res_strb = eff_mode ? eff_col_en : N_COL'(1);
    for (int k = 0; k < N_COL; k++) begin
      if (eff_pad_en) begin
        res_data[k] = res_strb[k] ? eff_pad_value : '0;
      end else begin
        res_data[k] = acc_upd[k];
      end
    end
  end

  // Next-state logic for the group FSM
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = StIdle;
    end else if (beat_acc) begin
      state_d = last_beat ? StOut : StAccum;
    end else if (state_q == StOut && out_ready_i) begin
      state_d = StIdle;
    end
  end

  // State, accumulators, config capture and the output register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      beat_cnt_q  <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      mode_q      <= 1'b0;
      nbeats_q    <= OneBeat;
      signed_q    <= 1'b0;
      col_en_q    <= '0;
      pad_en_q    <= 1'b0;
      pad_value_q <= '0;
    end else if (clear_i) begin
      state_q     <= StIdle;
      beat_cnt_q  <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
    end else begin
      state_q <= state_d;
      if (out_valid_q && out_ready_i) begin
        out_valid_q <= 1'b0;
      end
      if (beat_acc) begin
        if (first_beat) begin
          mode_q      <= cfg_mode_i;
          nbeats_q    <= nbeats_norm;
          signed_q    <= cfg_signed_i;
          col_en_q    <= cfg_col_en_i;
          pad_en_q    <= cfg_pad_en_i;
          pad_value_q <= cfg_pad_value_i;
        end
        if (last_beat) begin
          out_data_q  <= res_data;
          out_strb_q  <= res_strb;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
          beat_cnt_q  <= '0;
        end else begin
          acc_q      <= acc_upd;
          beat_cnt_q <= beat_cnt_q + OneBeat;
        end
      end
    end
  end

endmodule

// File: tb/tb_neureka_binconv_pe_accum.sv
// Scoreboard bench for neureka_binconv_pe_accum with 4 columns of 8-bit sums, up to 4 beats.
module tb_neureka_binconv_pe_accum;

  localparam int unsigned N_COL     = 4;
  localparam int unsigned COL_W     = 8;
  localparam int unsigned MAX_BEATS = 4;
  localparam int unsigned ACC_W     = 14;
  localparam int unsigned BCNT_W    = 3;

  typedef struct packed {
    logic [N_COL*ACC_W-1:0] data;
    logic [N_COL-1:0]       strb;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   clear;
  logic                   cfg_mode;
  logic [BCNT_W-1:0]      cfg_nbeats;
  logic                   cfg_signed;
  logic [N_COL-1:0]       cfg_col_en;
  logic                   cfg_pad_en;
  logic [ACC_W-1:0]       cfg_pad_value;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_COL*COL_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [N_COL*ACC_W-1:0] out_data;
  logic [N_COL-1:0]       out_strb;
  logic                   busy;
  logic [BCNT_W-1:0]      beat_cnt;

  int checks   = 0;
  int failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  neureka_binconv_pe_accum #(
    .N_COL    (N_COL),
    .COL_W    (COL_W),
    .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clear_i        (clear),
    .cfg_mode_i     (cfg_mode),
    .cfg_nbeats_i   (cfg_nbeats),
    .cfg_signed_i   (cfg_signed),
    .cfg_col_en_i   (cfg_col_en),
    .cfg_pad_en_i   (cfg_pad_en),
    .cfg_pad_value_i(cfg_pad_value),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
    .out_strb_o     (out_strb),
    .busy_o         (busy),
    .beat_cnt_o     (beat_cnt)
  );

  function automatic logic [N_COL*COL_W-1:0] d4(input logic [7:0] c0, input logic [7:0] c1,
                                                 input logic [7:0] c2, input logic [7:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [N_COL*ACC_W-1:0] l4(input logic [13:0] a0, input logic [13:0] a1,
                                                 input logic [13:0] a2, input logic [13:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [N_COL*ACC_W-1:0] d, input logic [N_COL-1:0] s);
    exp_t e;
    e.data = d;
    e.strb = s;
    exp_q.push_back(e);
  endtask

  task automatic set_cfg(input logic m, input logic [BCNT_W-1:0] nb, input logic sg,
                         input logic [N_COL-1:0] en, input logic pe, input logic [ACC_W-1:0] pv);
    cfg_mode      = m;
    cfg_nbeats    = nb;
    cfg_signed    = sg;
    cfg_col_en    = en;
    cfg_pad_en    = pe;
    cfg_pad_value = pv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and holds it until accepted (bounded wait)
  task automatic beat(input logic [N_COL*COL_W-1:0] d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL beat_ready_timeout: in_ready stayed %0b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: data %0h strb %0h with empty scoreboard",
                 out_data, out_strb);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_data !== e.data || out_strb !== e.strb) begin
          failures++;
          $display("FAIL output: data %0h strb %0h, required data %0h strb %0h",
                   out_data, out_strb, e.data, e.strb);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    set_cfg(1'b0, 3'd1, 1'b0, 4'b1111, 1'b0, '0);
    tick();
    tick();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_out_strb", 64'(out_strb), 64'd0);
    check("reset_beat_cnt", 64'(beat_cnt), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // SUM, single beat
    expect_out(l4(14'd10, 14'd0, 14'd0, 14'd0), 4'b0001);
    beat(d4(8'd1, 8'd2, 8'd3, 8'd4));
    check("sum_nb1_latency", 64'(out_valid), 64'd1);
    tick();

    // nbeats=0 behaves as a single beat
    set_cfg(1'b0, 3'd0, 1'b0, 4'b1111, 1'b0, '0);
    expect_out(l4(14'd4, 14'd0, 14'd0, 14'd0), 4'b0001);
    beat(d4(8'd1, 8'd1, 8'd1, 8'd1));
    check("nb0_as_one", 64'(out_valid), 64'd1);
    tick();

    // SUM unsigned 3 beats; mid-group config change must be ignored
    set_cfg(1'b0, 3'd3, 1'b0, 4'b1111, 1'b0, '0);
    beat(d4(8'd1, 8'd1, 8'd1, 8'd1));
    check("nb3_cnt1", 64'(beat_cnt), 64'd1);
    check("nb3_no_early_out", 64'(out_valid), 64'd0);
    set_cfg(1'b1, 3'd1, 1'b1, 4'b0000, 1'b1, 14'd77);
    beat(d4(8'd1, 8'd1, 8'd1, 8'd1));
    check("nb3_cnt2", 64'(beat_cnt), 64'd2);
    check("nb3_busy", 64'(busy), 64'd1);
    expect_out(l4(14'd28, 14'd0, 14'd0, 14'd0), 4'b0001);
    beat(d4(8'd1, 8'd1, 8'd1, 8'd1));
    tick();

    // nbeats above MAX_BEATS clamps to 4 beats: 4*(1+2+4+8)=60
    set_cfg(1'b0, 3'd7, 1'b0, 4'b1111, 1'b0, '0);
    for (int i = 0; i < 3; i++) beat(d4(8'd1, 8'd1, 8'd1, 8'd1));
    check("clamp_cnt3", 64'(beat_cnt), 64'd3);
    expect_out(l4(14'd60, 14'd0, 14'd0, 14'd0), 4'b0001);
    beat(d4(8'd1, 8'd1, 8'd1, 8'd1));
    tick();

    // SUM signed 2 beats: 1 - 2 = -1
    set_cfg(1'b0, 3'd2, 1'b1, 4'b1111, 1'b0, '0);
    beat(d4(8'd1, 8'd0, 8'd0, 8'd0));
    expect_out(l4(14'h3fff, 14'd0, 14'd0, 14'd0), 4'b0001);
    beat(d4(8'd1, 8'd0, 8'd0, 8'd0));
    tick();

    // DEPTHWISE, partial enable, negative column masked off
    set_cfg(1'b1, 3'd1, 1'b0, 4'b0101, 1'b0, '0);
    expect_out(l4(14'd5, 14'd0, 14'd7, 14'd0), 4'b0101);
    beat(d4(8'd5, 8'hfd, 8'd7, 8'd9));
    tick();

    // DEPTHWISE signed 2 beats: lane k = d0_k - 2
    set_cfg(1'b1, 3'd2, 1'b1, 4'b1111, 1'b0, '0);
    beat(d4(8'd1, 8'd2, 8'd3, 8'd4));
    expect_out(l4(14'h3fff, 14'd0, 14'd1, 14'd2), 4'b1111);
    beat(d4(8'd1, 8'd1, 8'd1, 8'd1));
    tick();

    // Padding in SUM and DEPTHWISE
    set_cfg(1'b0, 3'd2, 1'b0, 4'b1111, 1'b1, 14'd123);
    beat(d4(8'd9, 8'd9, 8'd9, 8'd9));
    check("pad_counts_beats", 64'(beat_cnt), 64'd1);
    expect_out(l4(14'd123, 14'd0, 14'd0, 14'd0), 4'b0001);
    beat(d4(8'd9, 8'd9, 8'd9, 8'd9));
    tick();
    set_cfg(1'b1, 3'd1, 1'b0, 4'b0110, 1'b1, 14'd123);
    expect_out(l4(14'd0, 14'd123, 14'd123, 14'd0), 4'b0110);
    beat(d4(8'd9, 8'd9, 8'd9, 8'd9));
    tick();

    // Backpressure: output held stable, then a beat in the pop cycle
    set_cfg(1'b0, 3'd1, 1'b0, 4'b1111, 1'b0, '0);
    out_ready = 1'b0;
    expect_out(l4(14'd4, 14'd0, 14'd0, 14'd0), 4'b0001);
    beat(d4(8'd1, 8'd1, 8'd1, 8'd1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_data", 64'(out_data), 64'(l4(14'd4, 14'd0, 14'd0, 14'd0)));
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    expect_out(l4(14'd8, 14'd0, 14'd0, 14'd0), 4'b0001);
    beat(d4(8'd2, 8'd2, 8'd2, 8'd2));
    check("pop_beat_valid", 64'(out_valid), 64'd1);
    check("pop_beat_data", 64'(out_data[13:0]), 64'd8);
    tick();

    // Soft clear after 2 of 4 beats drops the partial group and the beat under clear
    set_cfg(1'b0, 3'd4, 1'b0, 4'b1111, 1'b0, '0);
    beat(d4(8'd1, 8'd1, 8'd1, 8'd1));
    beat(d4(8'd1, 8'd1, 8'd1, 8'd1));
    check("pre_clear_cnt", 64'(beat_cnt), 64'd2);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = d4(8'd1, 8'd1, 8'd1, 8'd1);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_cnt", 64'(beat_cnt), 64'd0);
    check("clear_busy", 64'(busy), 64'd0);
    set_cfg(1'b0, 3'd1, 1'b0, 4'b1111, 1'b0, '0);
    expect_out(l4(14'd1, 14'd0, 14'd0, 14'd0), 4'b0001);
    beat(d4(8'd1, 8'd0, 8'd0, 8'd0));
    tick();

    // Async reset while a result is pending
    out_ready = 1'b0;
    expect_out(l4(14'd4, 14'd0, 14'd0, 14'd0), 4'b0001);
    beat(d4(8'd1, 8'd1, 8'd1, 8'd1));
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #2;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_out_data", 64'(out_data), 64'd0);
    check("rst_mid_out_strb", 64'(out_strb), 64'd0);
    exp_q.delete();
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    expect_out(l4(14'd10, 14'd0, 14'd0, 14'd0), 4'b0001);
    beat(d4(8'd1, 8'd2, 8'd3, 8'd4));
    tick();
    tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
